// File: rtl/brick_wall.sv
// Brick grid for the Breakout datapath: existence bitmap, per-frame collision scan FSM
// and a registered pixel-inside-live-brick flag for the colouring stage.
module brick_wall #(
    parameter int COLS    = 5,
    parameter int ROWS    = 2,
    parameter int X0      = 64,
    parameter int Y0      = 16,
    parameter int PITCH_X = 128,
    parameter int PITCH_Y = 32,
    parameter int HW      = 60,
    parameter int HH      = 12,
    parameter int R_BALL  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [9:0] x_ball,
    input  logic [9:0] y_ball,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic       area,
    output logic [3:0] area_row,
    output logic       hit_block,
    output logic       hit_block_up,
    output logic       hit_block_down,
    output logic       hit_block_left,
    output logic       hit_block_right,
    output logic [4:0] bricks_left,
    output logic       cleared
);

    localparam int N = ROWS * COLS;
    localparam logic [10:0] RX = 11'(HW + R_BALL);
    localparam logic [10:0] RY = 11'(HH + R_BALL);

    typedef enum logic [1:0] {StIdle, StScan, StHit} state_t;

    state_t       state;
    logic [3:0]   idx;
    logic [N-1:0] alive;
    logic [15:0]  alive_ext;

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction

    assign cleared   = start && (bricks_left == 5'd0);
    assign alive_ext = 16'(alive);

    // Collision evaluation for the brick currently selected by idx
    logic signed [10:0] xc_sel, yc_sel, dx, dy;
    logic [10:0]        adx, ady, px, py;
    logic               overlap;

    always_comb begin
        xc_sel = '0;
        yc_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == 4'(k)) begin
                xc_sel = 11'(X0 + (k % COLS) * PITCH_X);
                yc_sel = 11'(Y0 + (k / COLS) * PITCH_Y);
            end
        end
        dx      = $signed({1'b0, x_ball}) - xc_sel;
        dy      = $signed({1'b0, y_ball}) - yc_sel;
        adx     = abs11(dx);
        ady     = abs11(dy);
        px      = RX - adx;
        py      = RY - ady;
        overlap = alive_ext[idx] && (adx < RX) && (ady < RY);
    end

    always_ff @(posedge clock) begin
        if (reset || !start) begin
            state           <= StIdle;
            idx             <= '0;
            alive           <= '1;
            bricks_left     <= 5'(N);
            hit_block       <= 1'b0;
            hit_block_up    <= 1'b0;
            hit_block_down  <= 1'b0;
            hit_block_left  <= 1'b0;
            hit_block_right <= 1'b0;
        end else begin
            hit_block       <= 1'b0;
            hit_block_up    <= 1'b0;
            hit_block_down  <= 1'b0;
            hit_block_left  <= 1'b0;
            hit_block_right <= 1'b0;
            case (state)
                StIdle: begin
                    if (frame_tick && !cleared) begin
                        state <= StScan;
                        idx   <= '0;
                    end
                end
                StScan: begin
                    if (overlap) begin
                        state     <= StHit;
                        hit_block <= 1'b1;
                        // Shallower penetration axis decides the face; ties go vertical
                        if (px < py) begin
                            hit_block_left  <= dx[10];
                            hit_block_right <= ~dx[10];
                        end else begin
                            hit_block_up    <= dy[10];
                            hit_block_down  <= ~dy[10];
                        end
                    end else if (idx == 4'(N - 1)) begin
                        state <= StIdle;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                StHit: begin
                    for (int k = 0; k < N; k++) begin
                        if (idx == 4'(k)) alive[k] <= 1'b0;
                    end
                    bricks_left <= bricks_left - 5'd1;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Pixel path: lowest-index live brick containing the pixel supplies the row
    logic       area_d;
    logic [3:0] row_d;

    always_comb begin
        area_d = 1'b0;
        row_d  = '0;
        for (int k = 0; k < N; k++) begin
            if (!area_d && alive[k] &&
                abs11($signed({1'b0, next_x}) - 11'(X0 + (k % COLS) * PITCH_X)) <= 11'(HW) &&
                abs11($signed({1'b0, next_y}) - 11'(Y0 + (k / COLS) * PITCH_Y)) <= 11'(HH)) begin
                area_d = 1'b1;
                row_d  = 4'(k / COLS);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            area     <= 1'b0;
            area_row <= '0;
        end else begin
            area     <= area_d;
            area_row <= row_d;
        end
    end

endmodule
